// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of two bus masters access to a single
// en/ack memory port, with a write-only tristate data driver and an
// abort on missing ack.
module mem_arbiter #(
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_rdwr,
  input  logic          m1_rdwr,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_done,
  output logic          m1_done,
  output logic          m0_err,
  output logic          m1_err,
  output logic [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
  output logic          rdwr,
  output logic          en,
  input  logic          ack
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic          rdwr_q, rdwr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          oe_q, oe_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          win;

  // Next-state: arbitration in IDLE, handshake/timeout in ACCESS, one-cycle RELEASE.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    rdwr_d   = rdwr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    oe_d     = oe_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    win      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A lingering ack from the previous access holds off the next grant.
        if (!ack && (m0_req || m1_req)) begin
          win     = (m0_req && m1_req) ? ~last_q : m1_req;
          gnt_d   = win;
          last_d  = win;
          addr_d  = win ? m1_addr  : m0_addr;
          rdwr_d  = win ? m1_rdwr  : m0_rdwr;
          wdata_d = win ? m1_wdata : m0_wdata;
          oe_d    = win ? ~m1_rdwr : ~m0_rdwr;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (ack) begin
          en_d    = 1'b0;
          oe_d    = 1'b0;
          if (rdwr_q) begin
            if (gnt_q) rdata1_d = data;
            else       rdata0_d = data;
          end
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          state_d = S_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          en_d    = 1'b0;
          oe_d    = 1'b0;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          err0_d  = ~gnt_q;
          err1_d  = gnt_q;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      rdwr_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      oe_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      rdwr_q   <= rdwr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      oe_q     <= oe_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
    end
  end

  assign en       = en_q;
  assign rdwr     = rdwr_q;
  assign addr     = addr_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign m0_done  = done0_q;
  assign m1_done  = done1_q;
  assign m0_err   = err0_q;
  assign m1_err   = err1_q;
  assign data     = oe_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, hand-written sticky-ack
// and reset sequences, then randomized traffic against a transaction model.
module tb_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m1_req, m0_rdwr, m1_rdwr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_done, m1_done, m0_err, m1_err;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data;
  logic          rdwr, en, ack;
  logic          mem_oe;
  logic [DW-1:0] mem_dout;

  assign data = mem_oe ? mem_dout : {DW{1'bz}};

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_rdwr(m0_rdwr), .m1_rdwr(m1_rdwr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_done(m0_done), .m1_done(m1_done),
    .m0_err(m0_err), .m1_err(m1_err), .addr(addr), .data(data),
    .rdwr(rdwr), .en(en), .ack(ack)
  );

  int checks = 0;
  int errors = 0;

  // Per-master pending request and its parameters
  bit            pend [2];
  logic          p_rdwr [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];

  // Transaction-level model state
  int            mdl_last;
  logic [DW-1:0] mdl_rd [2];

  typedef struct {
    logic [1:0]    req;
    logic          rd0, rd1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] w0, w1;
    int            lat;    // ack sampled on this edge after grant, 0 = never
    logic [DW-1:0] rval;
    int            w;
    bit            err;
    logic [DW-1:0] e0, e1;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bus_free();
    return $isunknown(data) || (data == '0);
  endfunction

  task automatic drive_ports();
    m0_req = pend[0]; m0_rdwr = p_rdwr[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
    m1_req = pend[1]; m1_rdwr = p_rdwr[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
  endtask

  task automatic load(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    pend[i] = 1'b1; p_rdwr[i] = rw; p_addr[i] = a; p_wdata[i] = wd;
  endtask

  // Run one transaction from the current IDLE state and check every cycle of it.
  task automatic do_txn(input int lat, input logic [DW-1:0] rval, input int w, input bit exp_err,
                        input logic [DW-1:0] e0, input logic [DW-1:0] e1, input string tag);
    int g;
    int dk;
    bit got;
    drive_ports();
    ack = 1'b0; mem_oe = 1'b0;
    got = 1'b0; g = 0;
    while (g < 8 && !got) begin
      @(negedge clk);
      if (en) got = 1'b1;
      else g++;
    end
    chk({tag, " grant"}, 32'(got), 32'd1);
    if (!got) begin
      pend[0] = 1'b0; pend[1] = 1'b0; drive_ports();
      return;
    end
    chk({tag, " grant latency"}, g, 0);
    chk({tag, " addr"}, 32'(addr), 32'(p_addr[w]));
    chk({tag, " rdwr"}, 32'(rdwr), 32'(p_rdwr[w]));
    // Inputs changing during ACCESS must not disturb the access
    m0_addr = AW'($urandom); m1_addr = AW'($urandom);
    m0_rdwr = 1'($urandom);  m1_rdwr = 1'($urandom);
    m0_wdata = DW'($urandom); m1_wdata = DW'($urandom);
    dk = (lat >= 1 && lat <= int'(TO) + 1) ? lat : int'(TO) + 1;
    for (int k = 1; k <= dk; k++) begin
      ack = (k == lat);
      mem_oe = ack && p_rdwr[w];
      mem_dout = rval;
      if (!p_rdwr[w]) begin
        chk({tag, " write bus"}, 32'(data), 32'(p_wdata[w]));
        if (ack) mem_arr[p_addr[w]] = data;
      end else if (!mem_oe) begin
        chk({tag, " read bus free"}, 32'(bus_free()), 32'd1);
      end
      @(negedge clk);
      if (k < dk) begin
        chk({tag, " en held"}, 32'(en), 32'd1);
        chk({tag, " no early done"}, {30'd0, m1_done, m0_done}, 32'd0);
      end
    end
    chk({tag, " done"}, {30'd0, m1_done, m0_done}, (w == 1) ? 32'd2 : 32'd1);
    chk({tag, " err"}, {30'd0, m1_err, m0_err}, exp_err ? ((w == 1) ? 32'd2 : 32'd1) : 32'd0);
    chk({tag, " en dropped"}, 32'(en), 32'd0);
    chk({tag, " addr stable"}, 32'(addr), 32'(p_addr[w]));
    chk({tag, " m0_rdata"}, 32'(m0_rdata), 32'(e0));
    chk({tag, " m1_rdata"}, 32'(m1_rdata), 32'(e1));
    if (!p_rdwr[w] && !exp_err)
      chk({tag, " mem written"}, 32'(mem_arr[p_addr[w]]), 32'(p_wdata[w]));
    ack = 1'b0; mem_oe = 1'b0;
    pend[w] = 1'b0;
    drive_ports();
    @(negedge clk);
    chk({tag, " pulse end"}, {28'd0, m1_done, m0_done, m1_err, m0_err}, 32'd0);
    chk({tag, " release en"}, 32'(en), 32'd0);
    chk({tag, " release bus free"}, 32'(bus_free()), 32'd1);
  endtask

  // Predict winner/err/rdata from the round-robin rules, then run the transaction.
  task automatic model_txn(input int lat, input string tag);
    int w;
    bit e;
    logic [DW-1:0] rv;
    w  = (pend[0] && pend[1]) ? 1 - mdl_last : (pend[1] ? 1 : 0);
    rv = mem_arr[p_addr[w]];
    e  = !(lat >= 1 && lat <= int'(TO) + 1);
    if (!e && p_rdwr[w]) mdl_rd[w] = rv;
    mdl_last = w;
    do_txn(lat, rv, w, e, mdl_rd[0], mdl_rd[1], tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " en"}, 32'(en), 32'd0);
    chk({tag, " rdwr"}, 32'(rdwr), 32'd1);
    chk({tag, " addr"}, 32'(addr), 32'd0);
    chk({tag, " done/err"}, {28'd0, m1_done, m0_done, m1_err, m0_err}, 32'd0);
    chk({tag, " rdata"}, {m1_rdata, m0_rdata}, 32'd0);
    chk({tag, " bus free"}, 32'(bus_free()), 32'd1);
  endtask

  initial begin
    int g;
    int sel;
    int lat;
    tbl[0]  = '{2'b01, 1'b1, 1'b0, 12'h123, 12'h000, 16'h0000, 16'h0000, 2,  16'hBEEF, 0, 1'b0, 16'hBEEF, 16'h0000};
    tbl[1]  = '{2'b10, 1'b0, 1'b0, 12'h000, 12'h7FF, 16'h0000, 16'hA5A5, 1,  16'h0000, 1, 1'b0, 16'hBEEF, 16'h0000};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 12'h010, 12'h020, 16'h0000, 16'h0000, 1,  16'h1111, 0, 1'b0, 16'h1111, 16'h0000};
    tbl[3]  = '{2'b01, 1'b1, 1'b1, 12'h011, 12'h020, 16'h0000, 16'h0000, 3,  16'h2222, 1, 1'b0, 16'h1111, 16'h2222};
    tbl[4]  = '{2'b10, 1'b1, 1'b0, 12'h011, 12'h030, 16'h0000, 16'h1234, 1,  16'h3333, 0, 1'b0, 16'h3333, 16'h2222};
    tbl[5]  = '{2'b00, 1'b1, 1'b0, 12'h011, 12'h030, 16'h0000, 16'h1234, 2,  16'h0000, 1, 1'b0, 16'h3333, 16'h2222};
    tbl[6]  = '{2'b01, 1'b1, 1'b0, 12'h0AA, 12'h000, 16'h0000, 16'h0000, 0,  16'h9999, 0, 1'b1, 16'h3333, 16'h2222};
    tbl[7]  = '{2'b01, 1'b1, 1'b0, 12'h0AB, 12'h000, 16'h0000, 16'h0000, 1,  16'h4444, 0, 1'b0, 16'h4444, 16'h2222};
    tbl[8]  = '{2'b01, 1'b1, 1'b0, 12'h0AC, 12'h000, 16'h0000, 16'h0000, 15, 16'h5555, 0, 1'b0, 16'h5555, 16'h2222};
    tbl[9]  = '{2'b01, 1'b1, 1'b0, 12'h0AD, 12'h000, 16'h0000, 16'h0000, 16, 16'h6666, 0, 1'b0, 16'h6666, 16'h2222};
    tbl[10] = '{2'b10, 1'b0, 1'b0, 12'h000, 12'h0B0, 16'h0000, 16'hC3C3, 0,  16'h0000, 1, 1'b1, 16'h6666, 16'h2222};

    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = DW'($urandom);
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; p_rdwr[i] = 1'b1; p_addr[i] = '0; p_wdata[i] = '0;
    end
    rst = 1'b1; ack = 1'b0; mem_oe = 1'b0; mem_dout = '0;
    drive_ports();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Directed transaction table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].req[0]) load(0, tbl[i].rd0, tbl[i].a0, tbl[i].w0);
      if (tbl[i].req[1]) load(1, tbl[i].rd1, tbl[i].a1, tbl[i].w1);
      do_txn(tbl[i].lat, tbl[i].rval, tbl[i].w, tbl[i].err, tbl[i].e0, tbl[i].e1,
             $sformatf("vec%0d", i));
    end

    // Sticky ack: m1 waits while ack stays high, then is served normally
    load(1, 1'b1, 12'h040, 16'h0000);
    drive_ports();
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("sticky no grant", 32'(en), 32'd0);
    end
    ack = 1'b0;
    do_txn(1, 16'h7777, 1, 1'b0, 16'h6666, 16'h7777, "sticky");

    // Reset in the middle of an m1 access, with both masters requesting after
    load(1, 1'b1, 12'h055, 16'h0000);
    drive_ports();
    g = 0;
    while (g < 8 && !en) begin
      @(negedge clk);
      g++;
    end
    chk("rst grant", 32'(en), 32'd1);
    repeat (2) @(negedge clk);
    load(0, 1'b1, 12'h066, 16'h0000);
    drive_ports();
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    rst = 1'b0;
    mdl_last = 1;
    mdl_rd[0] = '0; mdl_rd[1] = '0;
    model_txn(1, "post-reset");

    // Randomized traffic against the transaction model
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && ($urandom_range(0, 1) == 1))
          load(i, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
      if (!pend[0] && !pend[1])
        load(int'($urandom_range(0, 1)), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
      sel = int'($urandom_range(0, 9));
      lat = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(14, 17)) : int'($urandom_range(1, 4));
      model_txn(lat, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single 12-bit-address / 16-bit-data memory port (`addr`, `data`, `rdwr`, `en`, `ack`) between the `cpu` and a second bus master (DMA / I/O engine). It sits between the masters and `memory`. It performs round-robin arbitration, runs the en/ack handshake on the masters' behalf, drives the bidirectional data bus only for writes, and aborts accesses that never receive `ack`.

## Interface
- `AW`, 12, address width
- `DW`, 16, data width
- `TIMEOUT`, 15, max cycles in ACCESS without `ack` before abort (≥1)

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `m0_req`, `m1_req`  in  1  access request, held until matching done
- `m0_rdwr`, `m1_rdwr`  in  1  1 = read, 0 = write
- `m0_addr`, `m1_addr`  in  AW  access address
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m0_rdata`, `m1_rdata`  out  DW  read data, registered
- `m0_done`, `m1_done`  out  1  one-cycle completion pulse
- `m0_err`, `m1_err`  out  1  one-cycle pulse with done on timeout
- `addr`  out  AW  memory address
- `data`  inout  DW  memory data bus
- `rdwr`  out  1  memory direction, 1 = read
- `en`  out  1  memory enable
- `ack`  in  1  memory acknowledge

## Operation
- FSM: IDLE, ACCESS, RELEASE. All outputs are registered. `data` is a tristate output enable from a register.
- Reset: state=IDLE, `en`=0, `rdwr`=1, `addr`=0, `data` high-Z, all done/err=0, all rdata=0, timeout count=0, last_grant=1 (so m0 wins first).
- IDLE: arbitration only when `ack`=0. If only one req is high, grant it. If both are high, grant the master ≠ last_grant. On grant: latch addr/rdwr/wdata of the winner, `en`<=1, count<=0, last_grant<=winner, go to ACCESS.
- A request seen while `ack` is still high from the previous access is held off until `ack` drops.
- ACCESS: `en`=1. `addr`/`rdwr` stay stable. For a write, `data` is driven with the latched wdata. For a read, `data` is Z. Each edge, count increments.
  - Ack path: `ack`=1 sampled → `en`<=0. For a read, rdata of the granted master <= `data`. done<=1. Go to RELEASE.
  - Timeout path: count==TIMEOUT and `ack`=0 → `en`<=0, done<=1, err<=1, rdata unchanged, go to RELEASE.
  - Ack and timeout on the same edge: the ack path wins, and err stays 0.
- RELEASE: done/err<=0. `data` returns to Z. `ack` is ignored. Go to IDLE.
- A master keeping req high after done starts a new request in IDLE. Round-robin guarantees the other master is served if it is also requesting.
- Master inputs are sampled only at grant. Changes during ACCESS have no effect.
- A req dropped before grant is never served. Dropping req during ACCESS does not abort the access.
- rdata holds its value until the next successful read by that master.
- Timeout counter width is clog2(TIMEOUT+1). It never wraps, because it leaves ACCESS at TIMEOUT.
- Reset mid-ACCESS: on the reset edge, `en` drops, the bus goes to Z, and no done is produced. An in-flight write may or may not complete at memory.

## Timing
- Grant edge E0 (IDLE, req=1, ack=0) → `en`=1 from E0.
- First ack sampling is at E1. If ack is sampled at edge Ek, done and rdata are valid in the cycle after Ek, for exactly one cycle.
- Best case: req→done is 2 edges, and a full transaction takes 3 cycles (ACCESS, RELEASE, IDLE).
- Timeout: done+err arrive TIMEOUT+1 edges after grant.
- Back-to-back from the same master: the next `en` rises no earlier than 2 edges after done, and only once `ack`=0.

## Test plan
- Single read: m0 reads 0x123, memory acks after 2 cycles with 0xBEEF → `en` high for exactly 2 cycles, `m0_done` 1-cycle pulse, `m0_rdata`=0xBEEF, `data` never driven by the arbiter.
- Single write: m1 writes 0xA5A5 to 0x7FF → `data`=0xA5A5 and `rdwr`=0 while `en`=1, Z otherwise, `m1_done` pulse, memory location holds 0xA5A5.
- Contention: m0 and m1 request together continuously → grants alternate m0, m1, m0, m1 with no master served twice in a row. The first grant after reset goes to m0.
- Timeout: memory never acks, TIMEOUT=15 → `m0_done` and `m0_err` pulse together 16 edges after grant, `m0_rdata` unchanged, next request is serviced normally. Ack on edge 15 → done with err=0.
- Sticky ack: memory holds `ack` 3 cycles after `en` drops while m1 is requesting → no grant until `ack`=0, then normal access.
- Reset mid-ACCESS: assert `rst` one cycle during ACCESS → `en`=0, `data` Z, no done. All outputs are at reset values, and m0 wins the next contention.
